// File: rtl/eth_pkt_rx.sv
// eth_pkt_rx: egress packet receiver with framing check, header extraction and descriptor FIFO
//
// Ports:
//   clk, resetN            clock and synchronous active-low reset
//   inData/inSop/inEop     64-bit switch egress beat, qualified by inVld (no backpressure)
//   pktVld/pktRdy          descriptor FIFO head handshake
//   pktDst/pktSrc          header word [63:32] / [31:0]
//   pktLen/pktErr          length in words (header included) and malformed flag
//   pktCsum                payload XOR checksum (0 unless ETH_PKT_RX_CSUM_EN is defined)
//   goodCnt/errCnt/dropCnt saturating statistics counters
//
// Optional feature macro: ETH_PKT_RX_CSUM_EN enables the per-packet payload checksum.
module eth_pkt_rx #(
  parameter int DESC_DEPTH = 4,
  parameter int MAX_WORDS  = 255
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [63:0] inData,
  input  logic        inSop,
  input  logic        inEop,
  input  logic        inVld,
  output logic        pktVld,
  input  logic        pktRdy,
  output logic [31:0] pktDst,
  output logic [31:0] pktSrc,
  output logic [7:0]  pktLen,
  output logic        pktErr,
  output logic [31:0] pktCsum,
  output logic [15:0] goodCnt,
  output logic [15:0] errCnt,
  output logic [15:0] dropCnt
);
  localparam int AW = $clog2(DESC_DEPTH);
  localparam int DW = 73;
  typedef enum logic {IDLE, BODY} state_t;

  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, c} + {15'b0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  state_t        r_state;
  logic [31:0]   r_dst, r_src;
  logic [7:0]    r_len;
  logic          r_err;
  // Completion stage: a terminating SOP can close the open packet and a
  // single-word packet on the same beat, so up to two descriptors are staged.
  logic          r_p0, r_p1, r_stray;
  logic [DW-1:0] r_d0, r_d1;
  logic [DW-1:0] r_mem [DESC_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic [15:0]   r_good, r_errc, r_drop;
  logic          w_ovf, w_err_n, w_pop, w_acc0, w_acc1;
  logic [7:0]    w_len_n;
  logic [AW:0]   w_free;
  logic [1:0]    w_nacc, w_ndrop, w_ngood, w_nerr;
  logic [DW-1:0] w_single;

  assign w_ovf    = r_len >= 8'(MAX_WORDS);
  assign w_len_n  = w_ovf ? r_len : r_len + 8'd1;
  assign w_err_n  = r_err | w_ovf;
  assign w_single = {inData, 8'd1, 1'b0};

`ifdef ETH_PKT_RX_CSUM_EN
  logic [31:0] r_csum, r_cs0, w_csum_n;
  logic [31:0] r_cmem [DESC_DEPTH];
  assign w_csum_n = r_csum ^ inData[63:32] ^ inData[31:0];
  assign pktCsum  = r_cmem[r_rd];
`else
  assign pktCsum = 32'd0;
`endif

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state <= IDLE;
      r_dst   <= '0;
      r_src   <= '0;
      r_len   <= '0;
      r_err   <= 1'b0;
      r_p0    <= 1'b0;
      r_p1    <= 1'b0;
      r_stray <= 1'b0;
      r_d0    <= '0;
      r_d1    <= '0;
`ifdef ETH_PKT_RX_CSUM_EN
      r_csum  <= '0;
      r_cs0   <= '0;
`endif
    end else begin
      r_p0    <= 1'b0;
      r_p1    <= 1'b0;
      r_stray <= 1'b0;
      if (inVld) begin
        if (inSop) begin
          if (r_state == BODY) begin
            r_p0 <= 1'b1;
            r_d0 <= {r_dst, r_src, r_len, 1'b1};
`ifdef ETH_PKT_RX_CSUM_EN
            r_cs0 <= r_csum;
`endif
          end
          r_dst <= inData[63:32];
          r_src <= inData[31:0];
          r_len <= 8'd1;
          r_err <= 1'b0;
`ifdef ETH_PKT_RX_CSUM_EN
          r_csum <= '0;
`endif
          if (inEop) begin
            // The single-word packet goes behind the closed one when both complete together.
            if (r_state == BODY) begin
              r_p1 <= 1'b1;
              r_d1 <= w_single;
            end else begin
              r_p0 <= 1'b1;
              r_d0 <= w_single;
`ifdef ETH_PKT_RX_CSUM_EN
              r_cs0 <= '0;
`endif
            end
            r_state <= IDLE;
          end else begin
            r_state <= BODY;
          end
        end else if (r_state == IDLE) begin
          r_stray <= 1'b1;
        end else begin
          r_len <= w_len_n;
          r_err <= w_err_n;
`ifdef ETH_PKT_RX_CSUM_EN
          r_csum <= w_csum_n;
`endif
          if (inEop) begin
            r_p0    <= 1'b1;
            r_d0    <= {r_dst, r_src, w_len_n, w_err_n};
            r_state <= IDLE;
`ifdef ETH_PKT_RX_CSUM_EN
            r_cs0 <= w_csum_n;
`endif
          end
        end
      end
    end
  end

  // A pop in the same cycle frees a slot for the incoming push.
  assign w_pop   = pktVld & pktRdy;
  assign w_free  = (AW+1)'(DESC_DEPTH) - r_cnt + {{AW{1'b0}}, w_pop};
  assign w_acc0  = r_p0 && (w_free != '0);
  assign w_acc1  = r_p1 && (w_free >= (AW+1)'(2));
  assign w_nacc  = {1'b0, w_acc0} + {1'b0, w_acc1};
  assign w_ndrop = {1'b0, r_p0 & ~w_acc0} + {1'b0, r_p1 & ~w_acc1};
  assign w_ngood = {1'b0, r_p0 & ~r_d0[0]} + {1'b0, r_p1};
  assign w_nerr  = {1'b0, r_p0 & r_d0[0]} + {1'b0, r_stray};

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_good <= '0;
      r_errc <= '0;
      r_drop <= '0;
      for (int i = 0; i < DESC_DEPTH; i++) begin
        r_mem[i] <= '0;
`ifdef ETH_PKT_RX_CSUM_EN
        r_cmem[i] <= '0;
`endif
      end
    end else begin
      if (w_acc0) r_mem[r_wr] <= r_d0;
      if (w_acc1) r_mem[r_wr + AW'(1)] <= r_d1;
`ifdef ETH_PKT_RX_CSUM_EN
      if (w_acc0) r_cmem[r_wr] <= r_cs0;
      if (w_acc1) r_cmem[r_wr + AW'(1)] <= 32'd0;
`endif
      r_wr   <= r_wr + AW'(w_nacc);
      r_rd   <= r_rd + AW'(w_pop);
      r_cnt  <= r_cnt + (AW+1)'(w_nacc) - (AW+1)'(w_pop);
      r_good <= sat_add(r_good, w_ngood);
      r_errc <= sat_add(r_errc, w_nerr);
      r_drop <= sat_add(r_drop, w_ndrop);
    end
  end

  assign pktVld = r_cnt != '0;
  assign {pktDst, pktSrc, pktLen, pktErr} = r_mem[r_rd];
  assign goodCnt = r_good;
  assign errCnt  = r_errc;
  assign dropCnt = r_drop;
endmodule

// File: doc/eth_pkt_rx.md
# eth_pkt_rx

Packet receiver for the egress side of the Ethernet switch. Consumes the switch's 64-bit output stream (data, SOP, EOP, valid), checks framing, and extracts the header of each packet. Queues one descriptor per packet (destination, source, length, error, optional checksum) in a small FIFO drained with a valid/ready handshake. Keeps saturating statistics counters for good, errored and dropped packets.

## Interface
Parameters:
- DESC_DEPTH, 4: descriptor FIFO entries; power of two, at least 2.
- MAX_WORDS, 255: largest legal packet length in 64-bit words, including the header word; at most 255.

Ports:
- clk  in  1  clock; every flop is updated on its rising edge.
- resetN  in  1  reset; synchronous and active-low.
- inData  in  64  switch egress data.
- inSop  in  1  start of packet; qualified by inVld.
- inEop  in  1  end of packet; qualified by inVld.
- inVld  in  1  beat valid. There is no backpressure: every valid beat is consumed.
- pktVld  out  1  descriptor available at the FIFO head.
- pktRdy  in  1  consumer accepts the head descriptor.
- pktDst  out  32  header word [63:32].
- pktSrc  out  32  header word [31:0].
- pktLen  out  8  packet length in words, header included.
- pktErr  out  1  packet is malformed (see Operation).
- pktCsum  out  32  payload checksum; 0 when ETH_PKT_RX_CSUM_EN is not defined.
- goodCnt  out  16  count of packets queued with pktErr=0.
- errCnt  out  16  count of framing errors.
- dropCnt  out  16  count of descriptors lost because the FIFO was full.

## Operation
- A beat is a cycle in which inVld=1. inSop and inEop are ignored when inVld=0.
- The FSM has two states, IDLE and BODY.
- IDLE:
  - Beat with inSop=1: latch the header (dst/src), set len=1 and clear err.
    - If inEop=1 on the same beat, the packet is a single word: complete it and stay in IDLE.
    - Otherwise go to BODY.
  - Beat with inSop=0: stray data. Discard it, errCnt+1, stay in IDLE. No descriptor is produced.
- BODY:
  - Beat with inSop=0: len+1, and the checksum is updated.
    - If inEop=1, complete the packet and go to IDLE.
  - Beat with inSop=1: missing EOP. Complete the current packet with err=1, then open the new packet from this beat exactly as IDLE would, including the single-word case.
  - Length overflow: if len would exceed MAX_WORDS, set err=1 and hold len at MAX_WORDS. The packet keeps accumulating until EOP or SOP.
- Completing a packet:
  - A descriptor is pushed into the FIFO.
  - If err=1, errCnt+1.
  - Otherwise goodCnt+1.
  - Each completed packet increments errCnt at most once. Stray beats count separately, once per beat.
- FIFO full at push:
  - The descriptor is dropped and dropCnt+1. goodCnt and errCnt are still updated.
  - If a pop (pktVld and pktRdy) occurs in the same cycle, the push succeeds and nothing is dropped.
- Counters saturate at 16'hFFFF.
- Handshake:
  - pktDst, pktSrc, pktLen, pktErr and pktCsum are stable while pktVld=1 and pktRdy=0.
  - A pop occurs on an edge where pktVld and pktRdy are both 1.
  - pktRdy is a don't-care while pktVld=0.
  - Read and write pointers wrap modulo DESC_DEPTH. The FIFO uses an occupancy counter of width log2(DESC_DEPTH)+1.

## Timing
- Reset (resetN=0 at a rising edge):
  - All outputs go to 0, the FSM to IDLE, and the FIFO is emptied.
  - A packet in progress is discarded without being counted.
  - Beats arriving while resetN=0 are ignored.
- Latency: a descriptor for a packet whose EOP (or terminating SOP) beat is sampled at edge t is visible with pktVld=1 after edge t+1, provided the FIFO was empty.
- Throughput: one beat per cycle, sustained. Back-to-back packets (EOP at t, SOP at t+1) need no idle cycle.
- Outputs are registered; there is no combinational path from the in* ports to any output.
- pktVld falls on the edge that pops the last entry. A push and a pop in the same cycle leave occupancy unchanged.

## Configuration
- ETH_PKT_RX_CSUM_EN defined:
  - The per-packet accumulator is cleared at SOP and XORs in {inData[63:32]^inData[31:0]} for every non-header beat.
  - The final value is stored in the descriptor and presented on pktCsum.
  - For single-word packets pktCsum=0.
- ETH_PKT_RX_CSUM_EN undefined: there is no accumulator logic and pktCsum is tied to 0. All other behaviour is identical.

## Test plan
- 3-word packet: header 64'h0000_0001_0000_0002, payload 64'h1, 64'h2. Required: pktDst=1, pktSrc=2, pktLen=3, pktErr=0, goodCnt=1. With the macro defined, pktCsum=32'h3.
- Single word with SOP and EOP on the same beat, then an immediate 2-word packet. Required: two descriptors, lengths 1 and 2, both error-free, no idle cycle inserted between them.
- SOP at beats 0 and 2 with EOP at beat 3. Required: first descriptor len=2, err=1; second descriptor len=2, err=0; errCnt=1, goodCnt=1.
- Stray beat with no SOP while IDLE. Required: no descriptor, errCnt=1.
- pktRdy held 0 while DESC_DEPTH+2 packets arrive. Required: DESC_DEPTH descriptors retained in order, dropCnt=2. Then pop on the same edge as a push while full: no drop.
- resetN pulled low for one edge in mid-packet, followed by a clean packet. Required: only the clean descriptor appears, and all counters read 0 except goodCnt=1.
